// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch unit: FSM state encoding and the buffered
// instruction entry.
package Bundle;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } FetchState;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } FetchEntry;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit_inst_buffer.sv
// InstBuffer: DEPTH-entry synchronous FIFO of fetched {pc, inst} pairs.
// The head is read straight from storage, so a push is visible next cycle.
module InstBuffer
  import Bundle::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  FetchEntry                    push_entry,
  input  logic                         pop,
  output FetchEntry                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam FetchEntry RESET_ENTRY = '{pc: RESET_PC, inst: 32'h0000_0000};

  FetchEntry         mem_q [DEPTH];
  FetchEntry         mem_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push_s, do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A full buffer may still be written when the head leaves in the same cycle.
  assign do_push_s = push && (!full || pop);
  assign do_pop_s  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_ENTRY;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: issues in-order instruction fetches, buffers returns for decode,
// and discards responses belonging to requests issued before a redirect.
module fetch_unit
  import Bundle::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_res_valid,
  input  logic [31:0] imem_res_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        dec_stall,
  output logic        dec_valid,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

  FetchState     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] occ_s;
  logic [CW:0]   inflight_s;
  logic          buf_full_s, buf_empty_s;
  logic          accept_s, resp_s, push_s, pop_s;
  FetchEntry     head_s, push_entry_s;

  // Requests are throttled so every in-flight response is guaranteed a slot.
  assign inflight_s     = {1'b0, outstanding_q} + {1'b0, occ_s};
  assign imem_req_valid = (state_q == FETCH) && (inflight_s < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign accept_s       = imem_req_valid && imem_req_ready;
  assign resp_s         = imem_res_valid && (outstanding_q != '0);
  assign push_s         = resp_s && (state_q == FETCH) && !redirect_valid
                          && (!buf_full_s || pop_s);
  assign pop_s          = !buf_empty_s && !dec_stall;
  assign push_entry_s   = '{pc: resp_pc_q, inst: imem_res_data};

  assign dec_valid = !buf_empty_s;
  assign dec_inst  = head_s.inst;
  assign dec_pc    = head_s.pc;

  InstBuffer #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) u_inst_buffer (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .head       (head_s),
    .full       (buf_full_s),
    .empty      (buf_empty_s),
    .count      (occ_s)
  );

  always_comb begin
    state_d       = state_q;
    drop_cnt_d    = drop_cnt_q;
    outstanding_d = outstanding_q + CW'(accept_s) - CW'(resp_s);
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
    end else begin
      fetch_pc_d = accept_s ? fetch_pc_q + PC_STEP : fetch_pc_q;
      resp_pc_d  = push_s ? resp_pc_q + PC_STEP : resp_pc_q;
    end
    // A redirect turns every request still in flight into one to be dropped.
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH, DRAIN: begin
        if (redirect_valid) begin
          drop_cnt_d = outstanding_d;
        end else if (state_q == DRAIN) begin
          drop_cnt_d = drop_cnt_q - CW'(resp_s);
        end else begin
          drop_cnt_d = drop_cnt_q;
        end
        state_d = (drop_cnt_d != '0) && (redirect_valid || state_q == DRAIN) ? DRAIN : FETCH;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2: instruction buffer entries, which is also the in-flight request limit.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_res_valid  input  1  in-order instruction return.
REQ-009 SHALL have port imem_res_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1  branch/kill redirect from control path (pc_sel != PC_4).
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port dec_stall  input  1  decode cannot accept this cycle.
REQ-013 SHALL have port dec_valid  output  1  dec_inst/dec_pc valid.
REQ-014 SHALL have port dec_inst  output  32  instruction to decode.
REQ-015 SHALL have port dec_pc  output  32  address of dec_inst.

Function
REQ-016 SHALL implement FSM states BOOT, FETCH and DRAIN.
REQ-017 SHALL transition BOOT->FETCH unconditionally one cycle after reset release, issuing no request while in BOOT.
REQ-018 SHALL assert imem_req_valid only in FETCH and only when outstanding + occupancy < DEPTH.
REQ-019 SHALL drive imem_req_addr = fetch_pc.
REQ-020 SHALL treat a request as accepted when imem_req_valid && imem_req_ready, then increment outstanding and set fetch_pc += 4 (mod 2^32, wrapping 32'hFFFF_FFFC->0).
REQ-021 SHALL, in FETCH, on imem_res_valid with outstanding > 0, push {resp_pc, imem_res_data} into the buffer, then decrement outstanding and set resp_pc += 4.
REQ-022 SHALL ignore imem_res_valid when outstanding == 0.
REQ-023 SHALL drive dec_valid = buffer not empty and present the head entry on dec_inst/dec_pc, with no bypass: the response at cycle N appears at the head no earlier than N+1.
REQ-024 SHALL dequeue the head when dec_valid && !dec_stall; push and pop in the same cycle are legal at any occupancy.
REQ-025 SHALL hold dec_inst/dec_pc stable while dec_valid && dec_stall.
REQ-026 SHALL, on redirect_valid, flush the buffer (dec_valid=0 next cycle), load fetch_pc and resp_pc with redirect_pc, and drop any response arriving that cycle.
REQ-027 SHALL have redirect win over a same-cycle accept: the accepted request counts as in flight and fetch_pc still takes redirect_pc.
REQ-028 SHALL, on redirect, set drop_cnt = outstanding after this cycle's accept/response accounting, going to DRAIN if drop_cnt > 0 and to FETCH otherwise.
REQ-029 SHALL, in DRAIN, discard each response, decrement drop_cnt and outstanding, issue no request, and return to FETCH when drop_cnt reaches 0.
REQ-030 SHALL, on a redirect while in DRAIN, retarget fetch_pc/resp_pc and recompute drop_cnt per REQ-028.
REQ-031 SHALL never let outstanding exceed DEPTH, occupancy exceed DEPTH, or push to a full buffer.

Reset
REQ-032 SHALL, on reset assertion, immediately set state=BOOT, fetch_pc=resp_pc=RESET_PC, outstanding=drop_cnt=0 and the buffer empty.
REQ-033 SHALL reset outputs to imem_req_valid=0, imem_req_addr=RESET_PC, dec_valid=0, dec_inst=0, dec_pc=RESET_PC.
REQ-034 SHALL, when reset asserts mid-operation, abandon in-flight requests; their responses after release are ignored per REQ-022.

Structure
REQ-035 SHALL place the FetchState enum and the FetchEntry struct {pc, inst} in package Bundle.
REQ-036 SHALL implement the buffer as one sub-module, InstBuffer: a DEPTH-entry synchronous FIFO with flush, full, empty and count outputs.

Verification
REQ-037 SHALL verify reset release with ready=1 and 1-cycle memory latency: BOOT, then requests at 0x0 and 0x4, dec_pc 0x0 then 0x4 on consecutive cycles.
REQ-038 SHALL verify dec_stall held 5 cycles with 2 entries buffered: imem_req_valid=0, dec_pc held at 0x0, no loss after release.
REQ-039 SHALL verify redirect to 0x100 with 2 outstanding: DRAIN drops both responses, next request at 0x100, first dec_pc=0x100.
REQ-040 SHALL verify redirect coinciding with a response and an accept: the response is dropped, drop_cnt=outstanding, and no stale instruction reaches decode.
REQ-041 SHALL verify RESET_PC=32'hFFFF_FFF8: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 in order.
REQ-042 SHALL verify a spurious imem_res_valid with outstanding=0: buffer unchanged, dec_valid stays 0.
